// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 7-segment scan decoder.
//   - SEG_0 .. SEG_F : active-low {g,f,e,d,c,b,a} patterns for hex digits
//   - SEG_BLANK      : all segments off
//   - segdec_state_t : frame FSM states
//   - seg_dec_t      : result of decoding one 7-bit pattern
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } segdec_state_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       err;
        logic       blank;
    } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg_pattern_decode
// Purely combinational lookup from an active-low 7-segment pattern back to
// the hex nibble it displays.
// Ports:
//   pattern : in  7-bit active-low segment pattern {g,f,e,d,c,b,a}
//   dec     : out nibble plus error / blank flags
// Configuration macro: SEGDEC_BLANK_EN
//   defined   -> SEG_BLANK decodes as a blank digit (nibble 0, blank=1)
//   undefined -> SEG_BLANK is treated like any other unknown pattern
// ---------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec
);

    // Unknown patterns report nibble 0 with the error flag set.
    always_comb begin
        dec.nib   = 4'h0;
        dec.err   = 1'b0;
        dec.blank = 1'b0;
        case (pattern)
            SEG_0: dec.nib = 4'h0;
            SEG_1: dec.nib = 4'h1;
            SEG_2: dec.nib = 4'h2;
            SEG_3: dec.nib = 4'h3;
            SEG_4: dec.nib = 4'h4;
            SEG_5: dec.nib = 4'h5;
            SEG_6: dec.nib = 4'h6;
            SEG_7: dec.nib = 4'h7;
            SEG_8: dec.nib = 4'h8;
            SEG_9: dec.nib = 4'h9;
            SEG_A: dec.nib = 4'hA;
            SEG_B: dec.nib = 4'hB;
            SEG_C: dec.nib = 4'hC;
            SEG_D: dec.nib = 4'hD;
            SEG_E: dec.nib = 4'hE;
            SEG_F: dec.nib = 4'hF;
`ifdef SEGDEC_BLANK_EN
            SEG_BLANK: dec.blank = 1'b1;
`endif
            default: dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
// Watches a multiplexed active-low 7-segment bus, waits for each digit
// strobe window to settle, decodes the pattern and assembles a full frame
// that is offered downstream with a valid/ready handshake.
// Ports:
//   clk       : in  system clock, rising edge
//   reset_n   : in  asynchronous active-low reset
//   seg_in    : in  active-low segments {g,f,e,d,c,b,a} (asynchronous)
//   dig_sel   : in  one-hot digit strobe (asynchronous)
//   out_ready : in  downstream accepts the frame
//   out_valid : out frame available
//   out_value : out decoded nibbles, digit i at [4i+3:4i]
//   out_err   : out per-digit unrecognised pattern
//   out_blank : out per-digit blank (only with SEGDEC_BLANK_EN)
// Configuration macro: SEGDEC_BLANK_EN enables blank-digit detection;
// without it out_blank is constant 0.
// ---------------------------------------------------------------------------
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic [NUM_DIGITS-1:0]   out_blank
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]                  seg_meta, seg_sync, seg_prev;
    logic [NUM_DIGITS-1:0]       dig_meta, dig_sync, dig_prev;
    logic [CNT_W-1:0]            cnt;
    logic                        stable_ok;
    logic                        capture;
    logic                        frame_done;
    logic [IDX_W-1:0]            dig_idx;
    seg_dec_t                    dec;
    segdec_state_t               state, state_next;
    logic [NUM_DIGITS-1:0]       got;
    logic [NUM_DIGITS-1:0][3:0]  nib_q;
    logic [NUM_DIGITS-1:0]       err_q;

    // Two-flop synchroniser on both buses, followed by a one-cycle history
    // register so the settle check can compare consecutive synced samples.
    // Idle reset values match an unlit display with no strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_meta <= SEG_BLANK;
            seg_sync <= SEG_BLANK;
            seg_prev <= SEG_BLANK;
            dig_meta <= '0;
            dig_sync <= '0;
            dig_prev <= '0;
        end else begin
            seg_meta <= seg_in;
            seg_sync <= seg_meta;
            seg_prev <= seg_sync;
            dig_meta <= dig_sel;
            dig_sync <= dig_meta;
            dig_prev <= dig_sync;
        end
    end

    // A window counts as settled only while both buses repeat and exactly
    // one strobe is active; capture fires once, on the final count step.
    assign stable_ok = (seg_sync == seg_prev) && (dig_sync == dig_prev) && $onehot(dig_sync);
    assign capture   = stable_ok && (cnt == CNT_CAP);

    // Stability counter, saturating so a long window yields one capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!stable_ok) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Binary index of the active strobe; only meaningful when one-hot.
    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sync[i]) begin
                dig_idx = IDX_W'(i);
            end
        end
    end

    seg_pattern_decode u_decode (
        .pattern (seg_sync),
        .dec     (dec)
    );

    // The frame completes when this capture fills the last missing digit.
    assign frame_done = capture && (&(got | dig_sync));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (frame_done) state_next = PRESENT;
            PRESENT: if (out_ready)  state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // FSM outputs: valid follows the registered state directly.
    always_comb begin
        out_valid = (state == PRESENT);
    end

    // Frame registers. Captures only land while collecting, so the frame is
    // frozen while presented; the handshake just clears the got mask and the
    // old values stay visible until overwritten by the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            got   <= '0;
            nib_q <= '0;
            err_q <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (capture) begin
                        got[dig_idx]   <= 1'b1;
                        nib_q[dig_idx] <= dec.nib;
`ifdef SEGDEC_BLANK_EN
                        err_q[dig_idx] <= dec.err;
`else
                        // The decoder never flags blank in this build, so
                        // folding it into err changes nothing.
                        err_q[dig_idx] <= dec.err | dec.blank;
`endif
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        got <= '0;
                    end
                end
                default: got <= '0;
            endcase
        end
    end

`ifdef SEGDEC_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q;

    // Per-digit blank flags, captured alongside the nibble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q <= '0;
        end else if (state == COLLECT && capture) begin
            blank_q[dig_idx] <= dec.blank;
        end
    end

    assign out_blank = blank_q;
`else
    assign out_blank = '0;
`endif

    assign out_value = nib_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
// Drives whole strobe windows onto the display bus and compares the frame
// outputs against a digit-level model: a window of LONG length captures,
// a window of SHORT length does not, captures are ignored while a frame is
// presented, and the handshake releases it.
// Honours SEGDEC_BLANK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int GAP_CYCLES    = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_value;
    logic [3:0]  out_err;
    logic [3:0]  out_blank;

    int checks = 0;
    int errors = 0;

    // Digit-level reference state.
    logic [3:0] m_nib [4];
    logic [3:0] m_err;
    logic [3:0] m_blank;
    logic [3:0] m_got;
    logic       m_present;

    logic [6:0] pat_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_err   (out_err),
        .out_blank (out_blank)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Look a pattern up in the hex table; the blank pattern is special only
    // when blank detection is built in.
    function automatic void modelDecode(input logic [6:0] pat, output logic [3:0] nib,
                                        output logic e, output logic b);
        nib = 4'h0;
        e   = 1'b1;
        b   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (pat_table[k] == pat) begin
                nib = 4'(k);
                e   = 1'b0;
            end
        end
`ifdef SEGDEC_BLANK_EN
        if (pat == 7'h7F) begin
            e = 1'b0;
            b = 1'b1;
        end
`endif
    endfunction

    function automatic logic [15:0] modelValue();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            v[4*k +: 4] = m_nib[k];
        end
        return v;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 4; k++) begin
            m_nib[k] = 4'h0;
        end
        m_err     = 4'h0;
        m_blank   = 4'h0;
        m_got     = 4'h0;
        m_present = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one digit pattern for len cycles, then an idle gap long enough
    // for any capture to have landed. Lengths of at least STABLE_CYCLES+2
    // capture; lengths below STABLE_CYCLES do not.
    task automatic applyStimulus(input int dig, input logic [6:0] pat, input int len);
        logic [3:0] n;
        logic       e;
        logic       b;
        dig_sel = 4'(1 << dig);
        seg_in  = pat;
        repeat (len) tick();
        dig_sel = 4'h0;
        seg_in  = 7'h7F;
        repeat (GAP_CYCLES) tick();
        if (len >= STABLE_CYCLES + 2 && !m_present) begin
            modelDecode(pat, n, e, b);
            m_nib[dig]   = n;
            m_err[dig]   = e;
            m_blank[dig] = b;
            m_got[dig]   = 1'b1;
            if (m_got == 4'hF) begin
                m_present = 1'b1;
            end
        end
    endtask

    task automatic checkFrame(input string tag);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(m_present));
        checkOutput({tag, "_value"}, 32'(out_value), 32'(modelValue()));
        checkOutput({tag, "_err"},   32'(out_err),   32'(m_err));
        checkOutput({tag, "_blank"}, 32'(out_blank), 32'(m_blank));
        tick();
    endtask

    task automatic doHandshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_present = 1'b0;
        m_got     = 4'h0;
        @(negedge clk);
        checkOutput({tag, "_hs_valid"}, 32'(out_valid), 32'h0);
        tick();
    endtask

    task automatic resetDut(input string tag);
        reset_n = 1'b0;
        #2;
        modelClear();
        checkOutput({tag, "_rst_valid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_rst_value"}, 32'(out_value), 32'h0);
        checkOutput({tag, "_rst_err"},   32'(out_err),   32'h0);
        checkOutput({tag, "_rst_blank"}, 32'(out_blank), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [6:0] pat;
        logic [3:0] n;
        logic       e;
        logic       b;
        int         dig;
        int         kind;
        int         len;

        reset_n   = 1'b0;
        dig_sel   = 4'h0;
        seg_in    = 7'h7F;
        out_ready = 1'b0;
        modelClear();
        repeat (3) tick();
        resetDut("init");

        // Frame 0x1A3F.
        applyStimulus(0, 7'h0E, 12);
        applyStimulus(1, 7'h30, 12);
        applyStimulus(2, 7'h08, 12);
        applyStimulus(3, 7'h79, 12);
        checkFrame("t1");
        checkOutput("t1_const_value", 32'(out_value), 32'h1A3F);
        doHandshake("t1");

        // Glitch shorter than the stability window.
        applyStimulus(0, 7'h40, 7);
        checkFrame("t2");
        applyStimulus(1, 7'h24, 7);
        checkFrame("t2b");

        // Invalid pattern on digit 2.
        applyStimulus(0, 7'h40, 12);
        applyStimulus(1, 7'h79, 12);
        applyStimulus(2, 7'h2A, 12);
        applyStimulus(3, 7'h24, 12);
        checkFrame("t3");
        checkOutput("t3_const_err", 32'(out_err), 32'h4);
        checkOutput("t3_const_nib2", 32'(out_value[11:8]), 32'h0);

        // Backpressure: new windows while the frame waits.
        applyStimulus(0, 7'h00, 12);
        applyStimulus(2, 7'h10, 12);
        checkFrame("t4");
        checkOutput("t4_const_value", 32'(out_value), 32'h2010);
        doHandshake("t4");
        applyStimulus(3, 7'h12, 11);
        applyStimulus(2, 7'h02, 10);
        applyStimulus(1, 7'h78, 13);
        checkFrame("t4_partial");
        applyStimulus(0, 7'h46, 12);
        checkFrame("t4_fresh");
        checkOutput("t4_const_fresh", 32'(out_value), 32'h567C);
        doHandshake("t4b");

        // Reset in the middle of a frame.
        applyStimulus(0, 7'h21, 12);
        applyStimulus(1, 7'h06, 12);
        resetDut("t5");
        applyStimulus(2, 7'h03, 12);
        applyStimulus(3, 7'h19, 12);
        checkFrame("t5_half");
        applyStimulus(0, 7'h21, 12);
        applyStimulus(1, 7'h06, 12);
        checkFrame("t5_full");
        doHandshake("t5");

        // Blank pattern on digit 3.
        applyStimulus(0, 7'h40, 12);
        applyStimulus(1, 7'h40, 12);
        applyStimulus(2, 7'h40, 12);
        applyStimulus(3, 7'h7F, 12);
        checkFrame("t6");
`ifdef SEGDEC_BLANK_EN
        checkOutput("t6_const_blank", 32'(out_blank), 32'h8);
        checkOutput("t6_const_err",   32'(out_err),   32'h0);
`else
        checkOutput("t6_const_err",   32'(out_err),   32'h8);
        checkOutput("t6_const_blank", 32'(out_blank), 32'h0);
`endif
        doHandshake("t6");

        // Randomised windows with random acceptance.
        for (int t = 0; t < 40; t++) begin
            dig  = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 5));
            if (kind <= 3) begin
                pat = pat_table[$urandom_range(0, 15)];
            end else if (kind == 4) begin
                do begin
                    pat = 7'($urandom_range(0, 127));
                    modelDecode(pat, n, e, b);
                end while (!e || pat == 7'h7F);
            end else begin
                pat = 7'h7F;
            end
            if ($urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(3, STABLE_CYCLES - 1));
            end else begin
                len = int'($urandom_range(STABLE_CYCLES + 2, STABLE_CYCLES + 6));
            end
            applyStimulus(dig, pat, len);
            checkFrame("rnd");
            if (m_present && $urandom_range(0, 1) == 1) begin
                doHandshake("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
